// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    localparam int unsigned SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor_by8.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with valid/ready on both sides.
module serial_subtractor_by8
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int unsigned   CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               d_bit;
    logic               br_next;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // Control FSM plus operand/result shift registers; D doubles as the result shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
            Bout      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= A;
                        b_sr     <= B;
                        br       <= Bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    D    <= {d_bit, D[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        Bout      <= br_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_by8.sv
// Scoreboard bench for serial_subtractor_by8 (WIDTH=8).
module tb_serial_subtractor_by8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] D;
    logic       Bout;

    logic       rand_rdy = 1'b0;
    logic       rdy_fixed = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
    } exp_t;

    exp_t sb[$];

    serial_subtractor_by8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Sole driver of out_ready: fixed level or random per cycle
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent adder reference used for the cross-check
    function automatic logic [8:0] add_ref(input logic [8:0] x, input logic [7:0] b, input logic bin);
        return x + {1'b0, b} + 9'(bin);
    endfunction

    // Push expected result whenever the DUT accepts an operand
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_t e;
            logic [8:0] diff;
            diff   = {1'b0, A} - {1'b0, B} - 9'(Bin);
            e.a    = A;
            e.b    = B;
            e.bin  = Bin;
            e.d    = diff[7:0];
            e.bout = diff[8];
            sb.push_back(e);
        end
    end

    // Pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("D", 32'(D), 32'(e.d));
                check_eq("Bout", 32'(Bout), 32'(e.bout));
                check_eq("adder_xcheck", 32'(add_ref({Bout, D}, e.b, e.bin)), 32'({1'b0, e.a}));
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi, output int t);
        int n;
        n        = 0;
        A        = a;
        B        = b;
        Bin      = bi;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        check_eq("accept_in_time", 32'(in_ready), 32'd1);
        t = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int bad;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Bin      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_D", 32'(D), 32'd0);
        check_eq("rst_Bout", 32'(Bout), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency and in_ready profile
        send(8'h1E, 8'h14, 1'b0, t1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check_eq($sformatf("lat_in_ready_T+%0d", i), 32'(in_ready), 32'd0);
            check_eq($sformatf("lat_out_valid_T+%0d", i), 32'(out_valid), 32'(i == 9));
        end
        @(negedge clk);
        check_eq("idle_after_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Borrow and boundary cases
        send(8'h14, 8'h1E, 1'b0, t1);
        send(8'h0A, 8'h0A, 1'b1, t1);
        send(8'h00, 8'h00, 1'b0, t1);
        drain();
        @(posedge clk);
        #1;

        // Backpressure: result must hold while out_ready is low
        rdy_fixed = 1'b0;
        send(8'h09, 8'h02, 1'b0, t1);
        bad = 0;
        while (!out_valid && bad < 40) begin
            bad++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_D", 32'(D), 32'h07);
            check_eq("bp_Bout", 32'(Bout), 32'd0);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rdy_fixed = 1'b1;
        @(negedge clk);
        check_eq("bp_hs_valid", 32'(out_valid && out_ready), 32'd1);
        @(negedge clk);
        check_eq("bp_idle_ready", 32'(in_ready), 32'd1);
        check_eq("bp_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Busy-drop: second op held during SHIFT accepted only after IDLE
        send(8'hFF, 8'h01, 1'b0, t1);
        send(8'h00, 8'h01, 1'b0, t2);
        check_eq("busy_accept_gap", 32'(t2 - t1), 32'd10);
        drain();
        @(posedge clk);
        #1;

        // Reset mid-operation
        send(8'h80, 8'h01, 1'b0, t1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check_eq("midrst_no_pulse", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        send(8'h05, 8'h03, 1'b0, t1);
        drain();
        @(posedge clk);
        #1;

        // Random operands with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), t1);
        end
        drain();
        rand_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
